// File: rtl/cx_deserializer.sv
// cx_deserializer: collects a serial LSB-first bitstream into CW_WIDTH-bit codewords for the (11,7) syndrome decoder.
// Latency: a codeword appears on cx/cx_valid one cycle after the clock that captures its last bit (no bypass).
// Backpressure: one-entry output slot; a word completing while the slot is held drops and sets sticky overflow.
// Optional build macro CX_DESER_TIMEOUT_EN: aborts a frame after TIMEOUT_CYCLES consecutive idle cycles in RECV.
module cx_deserializer #(
    parameter int CW_WIDTH       = 11,
    parameter int CNT_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sin,
    input  logic                sin_valid,
    input  logic                sof,
    output logic [CW_WIDTH-1:0] cx,
    output logic                cx_valid,
    input  logic                cx_ready,
    output logic                busy,
    output logic                frame_err,
    output logic                overflow,
    input  logic                clr_ovf
);

    // The bit counter must be able to address every codeword position.
    if (((1 << CNT_WIDTH) <= CW_WIDTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
        $error("cx_deserializer: CNT_WIDTH too small for CW_WIDTH, or TIMEOUT_CYCLES < 1");
    end

    localparam logic [0:0]           ST_IDLE  = 1'b0;
    localparam logic [0:0]           ST_RECV  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] LAST_POS = CNT_WIDTH'(CW_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Frame assembly state
    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CW_WIDTH-1:0]  r_shift;

    // Output slot and status
    logic [CW_WIDTH-1:0]  r_cx;
    logic                 r_cx_valid;
    logic                 r_frame_err;
    logic                 r_overflow;

    // Per-cycle decode
    logic                 w_accept;     // this bit is written into the shift register
    logic                 w_restart;    // sof arrived while a frame was already open
    logic [CNT_WIDTH-1:0] w_pos;        // position the incoming bit lands in
    logic                 w_complete;   // this bit fills the last position
    logic                 w_slot_free;  // output slot can take a word at this edge
    logic                 w_take;       // completed word goes to the output slot
    logic                 w_drop;       // completed word is lost to a held slot
    logic                 w_timeout;    // open frame abandoned for being idle too long
    logic [CW_WIDTH-1:0]  w_word;       // shift register with the incoming bit merged in

    // Decode the incoming bit against the current frame state
    always_comb begin
        w_accept    = sin_valid & (sof | (r_state == ST_RECV));
        w_restart   = sin_valid & sof & (r_state == ST_RECV);
        w_pos       = sof ? '0 : r_cnt;
        w_complete  = w_accept & (w_pos == LAST_POS);
        w_slot_free = ~r_cx_valid | cx_ready;
        w_take      = w_complete & w_slot_free;
        w_drop      = w_complete & ~w_slot_free;
    end

    // Merge the incoming bit at its position so a completing word can be loaded in one edge
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < CW_WIDTH; i++) begin
            if (CNT_WIDTH'(i) == w_pos) begin
                w_word[i] = sin;
            end
        end
    end

`ifdef CX_DESER_TIMEOUT_EN
    localparam int               TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] r_idle;

    // The idle gap ends the frame on the edge where the counter would reach TIMEOUT_CYCLES
    always_comb begin
        w_timeout = (r_state == ST_RECV) & ~sin_valid & (r_idle == TO_LAST);
    end

    // Count consecutive idle cycles inside a frame; held at zero outside RECV
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if ((r_state != ST_RECV) || sin_valid || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TO_ONE;
        end
    end
`else
    // Without the timeout a frame may stall in RECV indefinitely
    always_comb begin
        w_timeout = 1'b0;
    end
`endif

    // Frame FSM, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= w_word;
            if (w_complete) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= ST_RECV;
                r_cnt   <= w_pos + CNT_ONE;
            end
        end
    end

    // Single-cycle error pulse for an early restart or an abandoned frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_restart | w_timeout;
        end
    end

    // Output slot: load on completion when free, otherwise clear valid once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx       <= '0;
            r_cx_valid <= 1'b0;
        end else if (w_take) begin
            r_cx       <= w_word;
            r_cx_valid <= 1'b1;
        end else if (r_cx_valid & cx_ready) begin
            r_cx_valid <= 1'b0;
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign cx        = r_cx;
    assign cx_valid  = r_cx_valid;
    assign busy      = (r_state == ST_RECV);
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cx_deserializer.sv
// tb_cx_deserializer: directed table vectors plus hand-written corner sequences for cx_deserializer.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: cx_ready is driven per vector to exercise hold, consume, overflow and same-cycle reload.
module tb_cx_deserializer;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        sin_valid;
    logic        sof;
    logic [10:0] cx;
    logic        cx_valid;
    logic        cx_ready;
    logic        busy;
    logic        frame_err;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    cx_deserializer #(
        .CW_WIDTH       (11),
        .CNT_WIDTH      (4),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sof       (sof),
        .cx        (cx),
        .cx_valid  (cx_valid),
        .cx_ready  (cx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sin;
        logic        vld;
        logic        sof;
        logic        rdy;
        logic        clr;
        logic [10:0] e_cx;
        logic        e_vld;
        logic        e_busy;
        logic        e_ferr;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic add_row(input logic s, input logic v, input logic f, input logic r, input logic c,
                           input logic [10:0] ecx, input logic ev, input logic eb,
                           input logic ee, input logic eo);
        vec_t t;
        t.sin = s; t.vld = v; t.sof = f; t.rdy = r; t.clr = c;
        t.e_cx = ecx; t.e_vld = ev; t.e_busy = eb; t.e_ferr = ee; t.e_ovf = eo;
        tbl.push_back(t);
    endtask

    // 11 rows: bits 0..9 expect the "during" outputs, bit 10 the "after" outputs
    task automatic add_frame(input logic [10:0] w, input logic r, input logic lr,
                             input logic [10:0] cx0, input logic v0, input logic o0,
                             input logic [10:0] cx1, input logic v1, input logic o1);
        for (int k = 0; k < 11; k++) begin
            if (k < 10) add_row(w[k], 1'b1, (k == 0), r, 1'b0, cx0, v0, 1'b1, 1'b0, o0);
            else        add_row(w[k], 1'b1, 1'b0, lr, 1'b0, cx1, v1, 1'b0, 1'b0, o1);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic f, input logic r, input logic c);
        sin = s; sin_valid = v; sof = f; cx_ready = r; clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] outs();
        return {cx, cx_valid, busy, frame_err, overflow};
    endfunction

    initial begin
        logic [10:0] w;
        logic        early_vld;

        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; cx_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", 32'(outs()), 32'(15'h0));
        rst = 1'b0;

        // ---------------- vector table ----------------
        // single frame 0x74D, ready high, then consumed
        add_frame(11'h74D, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, 11'h74D, 1'b1, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h74D, 1'b0, 1'b0, 1'b0, 1'b0);
        // backpressure: 0x7FF held, 0x001 dropped, consume, then clear overflow
        add_frame(11'h7FF, 1'b0, 1'b0, 11'h74D, 1'b0, 1'b0, 11'h7FF, 1'b1, 1'b0);
        add_frame(11'h001, 1'b0, 1'b0, 11'h7FF, 1'b1, 1'b0, 11'h7FF, 1'b1, 1'b1);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b1);
        add_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b0);
        // simultaneous consume and load: 0x155 held, 0x2AA completes while ready
        add_frame(11'h155, 1'b0, 1'b0, 11'h7FF, 1'b0, 1'b0, 11'h155, 1'b1, 1'b0);
        add_frame(11'h2AA, 1'b0, 1'b1, 11'h155, 1'b1, 1'b0, 11'h2AA, 1'b1, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h2AA, 1'b0, 1'b0, 1'b0, 1'b0);
        // back-to-back frames with no gap
        add_frame(11'h0F0, 1'b1, 1'b1, 11'h2AA, 1'b0, 1'b0, 11'h0F0, 1'b1, 1'b0);
        add_frame(11'h30F, 1'b1, 1'b1, 11'h0F0, 1'b0, 1'b0, 11'h30F, 1'b1, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h30F, 1'b0, 1'b0, 1'b0, 1'b0);
        // idle: bit without sof ignored, sof without valid ignored
        add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h30F, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h30F, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sin, tbl[i].vld, tbl[i].sof, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d {cx,vld,busy,ferr,ovf}", i), 32'(outs()),
                32'({tbl[i].e_cx, tbl[i].e_vld, tbl[i].e_busy, tbl[i].e_ferr, tbl[i].e_ovf}));
        end

        // ---------------- early sof ----------------
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, (k == 0), 1'b1, 1'b0);
        chk("early_pre_busy", 32'(busy), 32'd1);
        chk("early_pre_ferr", 32'(frame_err), 32'd0);
        w = 11'h3A5;
        early_vld = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step(w[k], 1'b1, (k == 0), 1'b1, 1'b0);
            if (k < 10 && cx_valid) early_vld = 1'b1;
            if (k == 0) begin
                chk("early_ferr_pulse", 32'(frame_err), 32'd1);
                chk("early_busy_kept", 32'(busy), 32'd1);
            end
            if (k == 1) chk("early_ferr_clears", 32'(frame_err), 32'd0);
        end
        chk("early_no_aborted_word", 32'(early_vld), 32'd0);
        chk("early_word", 32'({cx, cx_valid}), 32'({11'h3A5, 1'b1}));

        // ---------------- overflow with clear in same cycle, then async reset ----------------
        w = 11'h055;
        for (int k = 0; k < 11; k++) step(w[k], 1'b1, (k == 0), 1'b0, (k == 10));
        chk("ovf_set_wins", 32'({cx, cx_valid, overflow}), 32'({11'h3A5, 1'b1, 1'b1}));
        w = 11'h0FF;
        for (int k = 0; k < 6; k++) step(w[k], 1'b1, (k == 0), 1'b0, 1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'(15'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        w = 11'h3C3;
        for (int k = 0; k < 11; k++) begin
            step(w[k], 1'b1, (k == 0), 1'b1, 1'b0);
            if (k == 0) chk("post_reset_no_ferr", 32'(frame_err), 32'd0);
            if (k == 9) chk("post_reset_not_yet_valid", 32'(cx_valid), 32'd0);
        end
        chk("post_reset_word", 32'({cx, cx_valid, overflow}), 32'({11'h3C3, 1'b1, 1'b0}));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_consumed", 32'(cx_valid), 32'd0);

        // ---------------- idle gap inside a frame ----------------
        w = 11'h19B;
`ifdef CX_DESER_TIMEOUT_EN
        for (int k = 0; k < 4; k++) step(w[k], 1'b1, (k == 0), 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 14) chk("to14_still_busy", 32'({busy, frame_err}), 32'({1'b1, 1'b0}));
            if (i == 15) chk("to15_abort", 32'({busy, frame_err, cx_valid}), 32'({1'b0, 1'b1, 1'b0}));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("to_ferr_one_cycle", 32'({frame_err, cx_valid}), 32'd0);
        for (int k = 0; k < 4; k++) step(w[k], 1'b1, (k == 0), 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall14_busy", 32'({busy, frame_err}), 32'({1'b1, 1'b0}));
        for (int k = 4; k < 11; k++) step(w[k], 1'b1, 1'b0, 1'b1, 1'b0);
        chk("stall14_word", 32'({cx, cx_valid, frame_err}), 32'({11'h19B, 1'b1, 1'b0}));
`else
        for (int k = 0; k < 4; k++) step(w[k], 1'b1, (k == 0), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_busy", 32'({busy, frame_err, cx_valid}), 32'({1'b1, 1'b0, 1'b0}));
        for (int k = 4; k < 11; k++) step(w[k], 1'b1, 1'b0, 1'b1, 1'b0);
        chk("stall_word", 32'({cx, cx_valid, frame_err}), 32'({11'h19B, 1'b1, 1'b0}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cx_deserializer.md
Name: cx_deserializer

Overview:
- Receive-side front end for the (11,7) block decoder. Collects a serial channel bitstream into 11-bit codewords.
- Presents each complete codeword on a valid/ready output register whose data bus drives the decoder's cx[10:0] input.
- Detects framing errors and output overruns.
- Sits between the channel bit-recovery logic and the combinational syndrome decoder.

Parameters:
- CW_WIDTH, 11, codeword length in bits; must match the decoder cx width.
- CNT_WIDTH, 4, bit-counter width; must satisfy 2^CNT_WIDTH > CW_WIDTH.
- TIMEOUT_CYCLES, 15, idle-gap limit inside a frame; used only when CX_DESER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- sin  input  1  serial channel bit
- sin_valid  input  1  sin is valid this cycle
- sof  input  1  start of frame; qualified by sin_valid, marks bit cx[0]
- cx  output  CW_WIDTH  assembled codeword; bit 0 is received first
- cx_valid  output  1  cx holds an unconsumed codeword
- cx_ready  input  1  downstream accepts cx this cycle
- busy  output  1  a frame is in progress (RECV state)
- frame_err  output  1  one-cycle pulse on an aborted or short frame
- overflow  output  1  sticky flag: a completed frame was dropped
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst=1): state=IDLE, bit count=0, shift register=0, cx=0, cx_valid=0, busy=0, frame_err=0, overflow=0. Reset during a frame discards the partial frame. No frame_err pulse is issued for it.
- Shift register: separate from the cx output register. The bit received at count k is written to position k (LSB first).
- FSM states: IDLE and RECV.
- IDLE:
  - sin_valid & sof: write sin to position 0, count=1, go to RECV.
  - sin_valid & !sof: bit ignored, no error.
- RECV: busy=1.
  - sin_valid & !sof: write sin to position count, count+1.
  - sin_valid & sof (early restart): frame_err pulses next cycle. The new frame starts with sin at position 0, count=1, state stays RECV.
  - !sin_valid: hold state.
- Completion: the cycle that writes position CW_WIDTH-1 completes the frame. Next cycle state=IDLE, count=0.
  - Output slot free (cx_valid=0, or cx_valid=1 & cx_ready=1 in that same cycle): cx <= assembled word, cx_valid=1 next cycle.
  - Slot occupied and not being consumed: word dropped, overflow set to 1. cx and cx_valid are unchanged.
- Output handshake:
  - A transfer occurs on a cycle with cx_valid=1 & cx_ready=1.
  - After a transfer, cx_valid=0 next cycle unless a new word is loaded in the same cycle; in that case cx_valid stays 1 and cx updates.
  - cx is stable while cx_valid=1 & cx_ready=0.
  - cx keeps its last value after it is consumed. Zero-latency bypass is not allowed: a word completed in cycle t is visible at t+1 at the earliest.
- overflow: cleared by clr_ovf=1. If a set event and clr_ovf occur in the same cycle, set wins.
- Back-to-back frames are allowed: completion and a new sof can arrive on consecutive cycles with no gap. Throughput is one bit per cycle.
- No arithmetic beyond the count increment. count never exceeds CW_WIDTH-1 in RECV.

Optional Feature:
- Macro: CX_DESER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RECV. It resets on every sin_valid and increments on each cycle with sin_valid=0.
  - When it reaches TIMEOUT_CYCLES: frame aborted, frame_err pulses for one cycle, state=IDLE, count=0, and no word is delivered.
  - The idle counter is reset to 0 by rst and on entry to RECV.
- Not defined: no idle counter. A frame may stall in RECV indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Single frame: send bits 1,0,1,1,0,0,1,0,1,1,1 LSB first with sof on the first bit and cx_ready=1 -> cx=11'b11101001101 (0x74D) with cx_valid=1 exactly one cycle after the 11th bit. Then cx_valid=0 next cycle; busy=0; no frame_err.
- Backpressure/overflow: hold cx_ready=0, send two full frames 0x7FF then 0x001 -> cx stays 0x7FF with cx_valid=1 and overflow=1 after the second frame. Raise cx_ready then pulse clr_ovf -> cx_valid=0 and overflow=0.
- Simultaneous consume and load: cx_valid=1 holding 0x155; the second frame (0x2AA) completes in the same cycle cx_ready=1 -> next cycle cx=0x2AA, cx_valid still 1, overflow=0.
- Early sof: sof asserted at bit 5 of a frame -> frame_err one-cycle pulse. The following 11 bits form the delivered word, and no word is produced for the aborted frame.
- Async reset mid-frame: assert rst after 6 bits, without a clock edge -> all outputs 0 immediately. After release, a fresh 11-bit frame 0x3C3 is delivered correctly.
- With CX_DESER_TIMEOUT_EN and TIMEOUT_CYCLES=15: stall sin_valid for 15 cycles after bit 4 -> frame_err pulse, busy=0, and no cx_valid. A stall of 14 cycles followed by the remaining bits -> normal delivery.
